univ_shift_reg: RTL and testbench

Parameterised universal shift register built on the team's D flip-flop stage, one flop per bit. It captures serial or parallel data, shifts it left or right, and holds it. It is the downstream consumer of the single-bit D storage element, grouping WIDTH of them into a word-wide register. A shift counter reports when the loaded word has fully drained, and an optional pattern-match flag can be compiled in.

---
 rtl/univ_shift_reg.sv | 78 +++++++
 tb/tb_univ_shift_reg.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with drain counter
// Optional compare flag enabled by defining USR_MATCH_EN.
module univ_shift_reg #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] PATTERN   = WIDTH'(4'b1011)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             sout_r,
  output logic             sout_l,
  output logic [4:0]       cnt,
  output logic             drained,
  output logic             match
);

  localparam logic [4:0] CNT_MAX = 5'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [4:0]       cnt_inc;

  // Shifts in either direction advance the counter until it pins at WIDTH.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 5'd1;

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    case (mode)
      2'b00: begin
        q_d   = q_q;
        cnt_d = cnt_q;
      end
      2'b01: begin
        q_d   = {sin_r, q_q[WIDTH-1:1]};
        cnt_d = cnt_inc;
      end
      2'b10: begin
        q_d   = {q_q[WIDTH-2:0], sin_l};
        cnt_d = cnt_inc;
      end
      default: begin
        q_d   = pin;
        cnt_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= RESET_VAL;
      cnt_q <= 5'd0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q       = q_q;
  assign q_bar   = ~q_q;
  assign sout_r  = q_q[0];
  assign sout_l  = q_q[WIDTH-1];
  assign cnt     = cnt_q;
  assign drained = (cnt_q == CNT_MAX);

`ifdef USR_MATCH_EN
  assign match = (q_q == PATTERN);
`else
  assign match = 1'b0;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [1:0]   mode;
  logic         sin_r;
  logic         sin_l;
  logic [W-1:0] pin;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;
  logic         sout_r;
  logic         sout_l;
  logic [4:0]   cnt;
  logic         drained;
  logic         match;

  int checks = 0;
  int errors = 0;

  int m_q;
  int m_cnt;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pin(pin), .q(q), .q_bar(q_bar), .sout_r(sout_r), .sout_l(sout_l),
    .cnt(cnt), .drained(drained), .match(match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour as integer arithmetic on the word value.
  task automatic model_edge(input int md, input int p, input int sl, input int sr);
    int mask;
    mask = (1 << W) - 1;
    case (md)
      1: begin
        m_q = (m_q >> 1) | (sr << (W - 1));
        if (m_cnt < W) m_cnt++;
      end
      2: begin
        m_q = ((m_q << 1) | sl) & mask;
        if (m_cnt < W) m_cnt++;
      end
      3: begin
        m_q   = p & mask;
        m_cnt = 0;
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    int exp_match;
`ifdef USR_MATCH_EN
    exp_match = (m_q == 'b1011) ? 1 : 0;
`else
    exp_match = 0;
`endif
    chk({tag, ".q"},       32'(q),       32'(m_q));
    chk({tag, ".q_bar"},   32'(q_bar),   32'((~m_q) & ((1 << W) - 1)));
    chk({tag, ".sout_r"},  32'(sout_r),  32'(m_q & 1));
    chk({tag, ".sout_l"},  32'(sout_l),  32'((m_q >> (W - 1)) & 1));
    chk({tag, ".cnt"},     32'(cnt),     32'(m_cnt));
    chk({tag, ".drained"}, 32'(drained), 32'(m_cnt == W));
    chk({tag, ".match"},   32'(match),   32'(exp_match));
  endtask

  // Called at a falling edge; drives inputs, takes one rising edge, checks at next falling edge.
  task automatic step(input logic [1:0] md, input logic [W-1:0] p, input logic sl, input logic sr,
                      input string tag);
    mode  = md;
    pin   = p;
    sin_l = sl;
    sin_r = sr;
    @(posedge clk);
    model_edge(int'(md), int'(p), int'(sl), int'(sr));
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    m_q   = 0;
    m_cnt = 0;
    check_all(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    mode  = 2'b00;
    pin   = '0;
    sin_l = 1'b0;
    sin_r = 1'b0;
    m_q   = 0;
    m_cnt = 0;
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    step(2'b11, 4'b1010, 1'b0, 1'b0, "load");
    chk("load.q_const", 32'(q), 32'h0000000a);
    step(2'b01, 4'b0000, 1'b0, 1'b1, "rsh1");
    chk("rsh1.q_const", 32'(q), 32'h0000000d);
    step(2'b01, 4'b0000, 1'b0, 1'b1, "rsh2");
    chk("rsh2.q_const", 32'(q), 32'h0000000e);
    chk("rsh2.cnt_const", 32'(cnt), 32'd2);

    step(2'b11, 4'b1010, 1'b0, 1'b0, "reload");
    step(2'b10, 4'b1111, 1'b1, 1'b1, "lsh");
    chk("lsh.q_const", 32'(q), 32'h00000005);
    for (int i = 0; i < 3; i++) step(2'b00, 4'b1111, 1'b1, 1'b1, "hold");
    chk("hold.cnt_const", 32'(cnt), 32'd1);

    step(2'b11, 4'b0101, 1'b0, 1'b0, "drain_ld");
    for (int i = 0; i < 4; i++) step(2'b01, 4'b0000, 1'b0, 1'b0, "drain");
    chk("drain.drained_const", 32'(drained), 32'd1);
    step(2'b01, 4'b0000, 1'b0, 1'b0, "sat");
    chk("sat.cnt_const", 32'(cnt), 32'd4);
    step(2'b11, 4'b1010, 1'b0, 1'b0, "sat_ld");
    chk("sat_ld.drained_const", 32'(drained), 32'd0);

    async_reset("async_rst");
    chk("async_rst.q_bar_const", 32'(q_bar), 32'h0000000f);

    step(2'b10, 4'b0000, 1'b1, 1'b0, "pat1");
    step(2'b10, 4'b0000, 1'b0, 1'b0, "pat2");
    step(2'b10, 4'b0000, 1'b1, 1'b0, "pat3");
    step(2'b10, 4'b0000, 1'b1, 1'b0, "pat4");
    chk("pat4.q_const", 32'(q), 32'h0000000b);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) async_reset("rnd_rst");
      step(2'($urandom_range(0, 3)), W'($urandom), 1'($urandom), 1'($urandom), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
